// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module : alu_mc_pkg / alu_mc_if
// Purpose: Opcode type for the multi-cycle ALU and the interface bundling its
//          operation handshake and result bus.
//   master modport : producer/consumer side (drives operation and out_ready)
//   slave  modport : alu_mc side (drives in_ready, result, flags, busy)
// Signals: in_valid/in_ready, instruction, op1, op2, imm,
//          out_valid/out_ready, result, eq, div_by_zero, busy
// Revision: 1.0 - initial release
// ============================================================================
package alu_mc_pkg;
  typedef logic [3:0] alu_instruction_t;

  localparam alu_instruction_t OP_ADD  = 4'd0;
  localparam alu_instruction_t OP_SUB  = 4'd1;
  localparam alu_instruction_t OP_MUL  = 4'd2;
  localparam alu_instruction_t OP_DIV  = 4'd3;
  localparam alu_instruction_t OP_ABS  = 4'd4;
  localparam alu_instruction_t OP_SLT  = 4'd5;
  localparam alu_instruction_t OP_SGT  = 4'd6;
  localparam alu_instruction_t OP_SEQ  = 4'd7;
  localparam alu_instruction_t OP_SNEZ = 4'd8;
  localparam alu_instruction_t OP_MIN  = 4'd9;
  localparam alu_instruction_t OP_SLLI = 4'd10;
  localparam alu_instruction_t OP_ADDI = 4'd11;
  localparam alu_instruction_t OP_MULI = 4'd12;
  localparam alu_instruction_t OP_DIVI = 4'd13;
endpackage

interface alu_mc_if #(
  parameter int WIDTH = 32
) ();
  logic                        in_valid;
  logic                        in_ready;
  alu_mc_pkg::alu_instruction_t instruction;
  logic [WIDTH-1:0]            op1;
  logic [WIDTH-1:0]            op2;
  logic [WIDTH-1:0]            imm;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            result;
  logic                        eq;
  logic                        div_by_zero;
  logic                        busy;

  modport master (
    output in_valid, instruction, op1, op2, imm, out_ready,
    input  in_ready, out_valid, result, eq, div_by_zero, busy
  );

  modport slave (
    input  in_valid, instruction, op1, op2, imm, out_ready,
    output in_ready, out_valid, result, eq, div_by_zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module : alu_mc
// Purpose: Multi-cycle ALU. Single-cycle ops complete in one registered stage;
//          DIV/DIVI use an iterative restoring divider (one quotient bit per
//          cycle, MSB first). Result is held until the consumer accepts it.
// Ports  : clk   - rising-edge clock
//          rst_n - asynchronous active-low reset
//          bus   - alu_mc_if.slave (operation handshake, result, flags, busy)
// Config : ALU_MC_DIV_EN - when defined, the iterative divider and DIV state
//          are built; otherwise DIV/DIVI return 0 in one cycle, busy = 0.
// Revision: 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_mc_if.slave    bus
);
  import alu_mc_pkg::*;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             eq_q, eq_d;
  logic             dbz_q, dbz_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_res;
  logic             w_eq;
  logic             w_dbz;
  logic             w_accept;

  // Load controls for the output register
  logic             w_ld;
  logic [WIDTH-1:0] w_ld_res;
  logic             w_ld_eq;
  logic             w_ld_dbz;

  assign w_accept = bus.in_valid && bus.in_ready;

  always_comb begin
    w_opb = ((bus.instruction == OP_ADDI) || (bus.instruction == OP_MULI) ||
             (bus.instruction == OP_DIVI)) ? bus.imm : bus.op2;
    w_res = '0;
    w_eq  = 1'b0;
    w_dbz = 1'b0;
    case (bus.instruction)
      OP_ADD, OP_ADDI: w_res = bus.op1 + w_opb;
      OP_SUB:          w_res = bus.op1 - bus.op2;
      OP_MUL, OP_MULI: w_res = bus.op1 * w_opb;
      OP_ABS:          w_res = {1'b0, bus.op1[WIDTH-2:0]};
      OP_SLT:          w_res = {{(WIDTH-1){1'b0}}, (bus.op1 < bus.op2)};
      OP_SGT:          w_res = {{(WIDTH-1){1'b0}}, (bus.op1 > bus.op2)};
      OP_SEQ: begin
        w_eq  = (bus.op1 == bus.op2);
        w_res = {{(WIDTH-1){1'b0}}, w_eq};
      end
      OP_SNEZ: begin
        w_eq  = (bus.op1 != '0);
        w_res = {{(WIDTH-1){1'b0}}, w_eq};
      end
      OP_MIN:          w_res = (bus.op1 < bus.op2) ? bus.op1 : bus.op2;
      OP_SLLI:         w_res = bus.op1 << bus.imm[SHW-1:0];
`ifdef ALU_MC_DIV_EN
      // Zero divisor is resolved here and never enters the divider.
      OP_DIV, OP_DIVI: begin
        if (w_opb == '0) begin
          w_res = '1;
          w_dbz = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DIV  = 1'b1;
  localparam int   CW      = $clog2(WIDTH);

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;    // holds dividend bits, shifted out MSB first
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_start_div;
  logic             w_div_done;

  assign w_start_div = w_accept &&
                       ((bus.instruction == OP_DIV) || (bus.instruction == OP_DIVI)) &&
                       (w_opb != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_start_div)   state_d = ST_DIV;
      ST_DIV:  if (cnt_q == '0)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Outputs / control
  always_comb begin
    bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    bus.busy     = (state_q == ST_DIV);
    w_div_done   = (state_q == ST_DIV) && (cnt_q == '0);
    w_ld         = (w_accept && !w_start_div) || w_div_done;
    w_ld_res     = w_div_done ? quo_d : w_res;
    w_ld_eq      = w_div_done ? 1'b0  : w_eq;
    w_ld_dbz     = w_div_done ? 1'b0  : w_dbz;
  end

  // Restoring divider step: trial-subtract the divisor from the shifted
  // remainder; keep the difference only when it did not borrow.
  assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, dvs_q};

  always_comb begin
    cnt_d = cnt_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    if (state_q == ST_IDLE) begin
      if (w_start_div) begin
        cnt_d = CW'(WIDTH - 1);
        dvs_d = w_opb;
        rem_d = '0;
        quo_d = bus.op1;
      end
    end else begin
      if (!w_diff[WIDTH]) begin
        rem_d = w_diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = w_rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
`else
  always_comb begin
    bus.in_ready = !out_valid_q || bus.out_ready;
    bus.busy     = 1'b0;
    w_ld         = w_accept;
    w_ld_res     = w_res;
    w_ld_eq      = w_eq;
    w_ld_dbz     = w_dbz;
  end
`endif

  // Output register: a new load wins over a drain on the same edge.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    eq_d        = eq_q;
    dbz_d       = dbz_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (w_ld) begin
      out_valid_d = 1'b1;
      result_d    = w_ld_res;
      eq_d        = w_ld_eq;
      dbz_d       = w_ld_dbz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      eq_q        <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      eq_q        <= eq_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.eq          = eq_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_mc
// Purpose: Directed self-checking bench for alu_mc (WIDTH = 32). Divider
//          checks follow ALU_MC_DIV_EN, matching the build of the design.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input alu_instruction_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
    bus.in_valid    = 1'b1;
    bus.instruction = op;
    bus.op1         = a;
    bus.op2         = b;
    bus.imm         = im;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.instruction = OP_ADD;
    bus.op1 = '0; bus.op2 = '0; bus.imm = '0; bus.out_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({bus.out_valid, bus.result, bus.eq, bus.div_by_zero, bus.busy} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b res=%h eq=%b dbz=%b busy=%b required all 0",
               bus.out_valid, bus.result, bus.eq, bus.div_by_zero, bus.busy);
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    present(OP_ADD, 32'd7, 32'd5, 32'd0);
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd12 || bus.eq !== 1'b0) begin
      errors++;
      $display("FAIL add: got ov=%b res=%h eq=%b required ov=1 res=0000000c eq=0",
               bus.out_valid, bus.result, bus.eq);
    end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: got ov=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    present(OP_SEQ, 32'h1234, 32'h1234, 32'd0);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd1 || bus.eq !== 1'b1 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_seq: got ov=%b res=%h eq=%b rdy=%b required ov=1 res=00000001 eq=1 rdy=1",
               bus.out_valid, bus.result, bus.eq, bus.in_ready);
    end
    present(OP_SNEZ, 32'd0, 32'h55, 32'd0);
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.eq !== 1'b0) begin
      errors++;
      $display("FAIL b2b_snez: got ov=%b res=%h eq=%b required ov=1 res=00000000 eq=0",
               bus.out_valid, bus.result, bus.eq);
    end
    cycle();
  endtask

  task automatic test_ops();
    alu_instruction_t op[11] = '{OP_SUB, OP_MUL, OP_ABS, OP_SLT, OP_SGT, OP_MIN,
                                 OP_SLLI, OP_ADDI, OP_MULI, OP_SNEZ, 4'hF};
    logic [31:0] a[11]  = '{32'd5, 32'h10000, 32'h80000005, 32'd3, 32'd3, 32'd9,
                            32'd1, 32'd10, 32'd6, 32'd5, 32'd5};
    logic [31:0] b[11]  = '{32'd7, 32'h10003, 32'd0, 32'd9, 32'd9, 32'd3,
                            32'd0, 32'd100, 32'd1000, 32'd0, 32'd5};
    logic [31:0] im[11] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                            32'h25, 32'hFFFFFFFF, 32'd7, 32'd0, 32'd0};
    logic [31:0] er[11] = '{32'hFFFFFFFE, 32'h00030000, 32'd5, 32'd1, 32'd0, 32'd3,
                            32'h20, 32'd9, 32'd42, 32'd1, 32'd0};
    logic        ee[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      present(op[i], a[i], b[i], im[i]);
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== er[i] || bus.eq !== ee[i] ||
          bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL ops[%0d]: got ov=%b res=%h eq=%b dbz=%b required ov=1 res=%h eq=%b dbz=0",
                 i, bus.out_valid, bus.result, bus.eq, bus.div_by_zero, er[i], ee[i]);
      end
    end
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_div();
`ifdef ALU_MC_DIV_EN
    logic [31:0] dv_a[2]  = '{32'd100, 32'hFFFFFFFF};
    logic [31:0] dv_b[2]  = '{32'd7, 32'd0};
    logic [31:0] dv_i[2]  = '{32'd0, 32'd1};
    logic [31:0] dv_e[2]  = '{32'd14, 32'hFFFFFFFF};
    alu_instruction_t dv_op[2] = '{OP_DIV, OP_DIVI};
    for (int t = 0; t < 2; t++) begin
      present(dv_op[t], dv_a[t], dv_b[t], dv_i[t]);
      cycle();
      bus.in_valid = 1'b0;
      for (int k = 1; k <= 31; k++) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL div%0d_busy[%0d]: got busy=%b rdy=%b ov=%b required busy=1 rdy=0 ov=0",
                   t, k, bus.busy, bus.in_ready, bus.out_valid);
        end
        cycle();
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL div%0d_busy_last: got %b required 1", t, bus.busy);
      end
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== dv_e[t] || bus.busy !== 1'b0 ||
          bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL div%0d_result: got ov=%b res=%h busy=%b dbz=%b required ov=1 res=%h busy=0 dbz=0",
                 t, bus.out_valid, bus.result, bus.busy, bus.div_by_zero, dv_e[t]);
      end
      cycle();
    end
`else
    present(OP_DIV, 32'd100, 32'd7, 32'd0);
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.busy !== 1'b0 ||
        bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_disabled: got ov=%b res=%h busy=%b dbz=%b required ov=1 res=0 busy=0 dbz=0",
               bus.out_valid, bus.result, bus.busy, bus.div_by_zero);
    end
    cycle();
`endif
  endtask

  task automatic test_div_zero();
`ifdef ALU_MC_DIV_EN
    logic [31:0] exp_r = 32'hFFFFFFFF;
    logic        exp_z = 1'b1;
`else
    logic [31:0] exp_r = 32'h0;
    logic        exp_z = 1'b0;
`endif
    present(OP_DIV, 32'd5, 32'd0, 32'd0);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero_busy_pre: got %b required 0", bus.busy);
    end
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== exp_r || bus.div_by_zero !== exp_z ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero: got ov=%b res=%h dbz=%b busy=%b required ov=1 res=%h dbz=%b busy=0",
               bus.out_valid, bus.result, bus.div_by_zero, bus.busy, exp_r, exp_z);
    end
    cycle();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL divzero_after: got busy=%b ov=%b required 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b1;
    present(OP_ADD, 32'd1, 32'd2, 32'd0);
    cycle();
    bus.out_ready = 1'b0;
    present(OP_SUB, 32'd10, 32'd4, 32'd0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready: got %b required 0", bus.in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd3 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ov=%b res=%h rdy=%b required ov=1 res=00000003 rdy=0",
                 k, bus.out_valid, bus.result, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_rdy: got %b required 1", bus.in_ready);
    end
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd6) begin
      errors++;
      $display("FAIL stall_sub: got ov=%b res=%h required ov=1 res=00000006",
               bus.out_valid, bus.result);
    end
    cycle();
  endtask

  task automatic test_reset_midop();
`ifdef ALU_MC_DIV_EN
    present(OP_DIV, 32'd100, 32'd7, 32'd0);
    cycle();
    bus.in_valid = 1'b0;
    repeat (9) cycle();
`else
    bus.out_ready = 1'b0;
    present(OP_ADD, 32'd1, 32'd1, 32'd0);
    cycle();
    bus.in_valid = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.result, bus.eq, bus.div_by_zero, bus.busy} !== 36'h0) begin
      errors++;
      $display("FAIL midop_reset: got ov=%b res=%h eq=%b dbz=%b busy=%b required all 0",
               bus.out_valid, bus.result, bus.eq, bus.div_by_zero, bus.busy);
    end
    bus.out_ready = 1'b1;
    cycle();
    #3;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b ov=%b busy=%b required rdy=1 ov=0 busy=0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    present(OP_ADD, 32'd20, 32'd22, 32'd0);
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd42) begin
      errors++;
      $display("FAIL post_reset_add: got ov=%b res=%h required ov=1 res=0000002a",
               bus.out_valid, bus.result);
    end
    cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_ops();
    test_div();
    test_div_zero();
    test_stall();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised-width successor to the lock-in datapath ALU. It accepts one `alu_instruction_t` operation per valid/ready handshake and executes single-cycle ops in one registered stage. DIV/DIVI run on an iterative restoring divider. The result is held in an output register until the consumer accepts it. It sits between the lock-in decode/register-read stage and writeback, replacing the purely combinational ALU where a `/` operator cannot close timing.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be ≥ 4 and a power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount bits used (derived; do not override).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: an operation is presented this cycle.
- `in_ready` out 1: the block accepts the operation this cycle.
- `instruction` in `alu_instruction_t`: opcode (ADD, SUB, MUL, DIV, ABS, SLT, SGT, SEQ, SNEZ, MIN, SLLI, ADDI, MULI, DIVI).
- `op1`, `op2`, `imm` in WIDTH each: operands.
- `out_valid` out 1: `result` and flags are valid.
- `out_ready` in 1: the consumer takes the result.
- `result` out WIDTH: the registered result.
- `eq` out 1: the registered EQ flag (SEQ/SNEZ only, else 0).
- `div_by_zero` out 1: the registered flag, 1 when a DIV/DIVI divisor was 0.
- `busy` out 1: the divider is iterating.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`. This is combinational, with no dependency on `in_valid`.
- All arithmetic is unsigned and modulo 2^WIDTH. Products keep only the low WIDTH bits.
- ABS: `{1'b0, op1[WIDTH-2:0]}`.
- SLT/SGT/SEQ/SNEZ: zero-extended 1 or 0.
- MIN: unsigned minimum of `op1` and `op2`.
- SLLI: `op1 << imm[SHW-1:0]`. Upper `imm` bits are ignored.
- ADDI/MULI/DIVI use `imm` as the second operand.
- `eq` is set only for SEQ (`op1 == op2`) and SNEZ (`op1 != 0`).
- Undefined opcodes give result 0 and all flags 0.
- DIV/DIVI quotient is truncated.
- Divisor 0: result is all-ones and `div_by_zero` = 1. The op completes in 1 cycle and does not enter DIV.
- FSM states:
  - IDLE: on accepting a non-divide op or a divide-by-zero op, load the output register and stay in IDLE. On accepting a divide with nonzero divisor, latch the operands, clear the remainder and set counter = WIDTH-1, then go to DIV.
  - DIV: one restoring step per cycle (shift remainder left, subtract, set the quotient bit), MSB first. When counter = 0, load `result` with the quotient, set `out_valid`, and go to IDLE. Otherwise decrement the counter.
- The output register holds its contents stable while `out_valid && !out_ready`.
- `out_valid` clears on a transfer out, unless the same edge loads a new result.
- `busy = (state == DIV)`.

## Timing
- Reset (async assert, sync release):
  - `out_valid`, `result`, `eq`, `div_by_zero`, `busy` = 0.
  - state = IDLE, counter = 0.
  - `in_ready` = 1 on the first cycle after release.
- Non-divide op: accepted at edge N; `out_valid` = 1 after edge N (latency 1).
- Back-to-back throughput is 1 op/cycle when `out_ready` is held high.
- Divide op: accepted at edge N; `busy` is high for WIDTH cycles; `out_valid` rises after edge N+WIDTH. `in_ready` is 0 throughout.
- Simultaneous transfer out and transfer in at the same edge: the new result replaces the old one and `out_valid` stays 1.
- Output stalled (`out_valid` high, `out_ready` low): `in_ready` = 0 and nothing is overwritten.
- A divide finishing while the previous result is unconsumed cannot occur, because entry into DIV requires the output slot to be free or draining.
- `rst_n` asserted mid-division aborts immediately to the reset state; no partial result appears.

## Configuration
- `ALU_MC_DIV_EN` defined:
  - The iterative divider and the DIV state are compiled in, as above.
- `ALU_MC_DIV_EN` undefined:
  - There is no divider logic and no DIV state.
  - DIV/DIVI complete in 1 cycle with `result` = 0 and `div_by_zero` = 0. `busy` is tied to 0.

## Test plan
- Reset release, then ADD `op1`=7, `op2`=5 with `out_ready`=1 → `out_valid` 1 cycle later, `result`=12, `eq`=0.
- SEQ 0x1234/0x1234, then SNEZ `op1`=0 back-to-back → `result`=1, `eq`=1; then `result`=0, `eq`=0, with no bubble between them.
- With `ALU_MC_DIV_EN` defined, WIDTH=32: DIV 100/7 → `in_ready`=0 and `busy`=1 for 32 cycles, then `result`=14. DIVI 0xFFFFFFFF/imm 1 → 0xFFFFFFFF.
- DIV 5/0 → 1-cycle latency, `result`=0xFFFFFFFF, `div_by_zero`=1, `busy` never asserts.
- Hold `out_ready`=0 after an ADD result while `in_valid`=1 with SUB → `result` stays stable and `in_ready`=0. Raise `out_ready` → SUB is accepted on that same edge and its result follows 1 cycle later.
- Assert `rst_n`=0 during cycle 10 of a division → all outputs are 0 immediately. After release, `in_ready`=1 and a new ADD completes correctly.
